decode_stage: RTL and testbench

- Registered, handshaked RV32 decode stage. Next generation of the combinational instruction decoder.
- Adds full RV32I coverage (JAL, JALR, FENCE, ECALL/EBREAK), an optional M-extension decode, optional RV32E register limits, and illegal-instruction detection.
- Adds a valid/ready pipeline interface with a 2-entry skid buffer and a flush input.
- Sits between instruction fetch and the register-file/ALU stage of the pipelined core.

---
 rtl/decode_stage.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Registered RV32I(+M/E) decode stage with a valid/ready interface.
// A one-entry output register and a one-entry skid register hold up to two decoded bundles.
module decode_stage #(
    parameter int ENABLE_M = 0,
    parameter int RV32E    = 0,
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic                write_en,
    output logic [4:0]          write_addr,
    output logic [4:0]          read_addr1,
    output logic [4:0]          read_addr2,
    output logic [31:0]         immediate,
    output logic [2:0]          funct3,
    output logic [6:0]          funct7,
    output logic [4:0]          alu_opcode,
    output logic                alu_src2_from_imm,
    output logic                mem_read_en,
    output logic                mem_write_en,
    output logic                branch_inst,
    output logic                jal_inst,
    output logic                jalr_inst,
    output logic                auipc_inst,
    output logic                sys_inst,
    output logic                illegal_inst
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef struct packed {
        logic        write_en;
        logic [4:0]  write_addr;
        logic [4:0]  read_addr1;
        logic [4:0]  read_addr2;
        logic [31:0] immediate;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  alu_opcode;
        logic        alu_src2_from_imm;
        logic        mem_read_en;
        logic        mem_write_en;
        logic        branch_inst;
        logic        jal_inst;
        logic        jalr_inst;
        logic        auipc_inst;
        logic        sys_inst;
        logic        illegal_inst;
    } bundle_t;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];
    assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u  = {in_inst[31:12], 12'b0};
    assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    bundle_t dec;
    logic    bad;
    logic    uses_rd;
    logic    uses_rs1;
    logic    uses_rs2;

    always_comb begin
        dec            = '0;
        bad            = 1'b0;
        uses_rd        = 1'b0;
        uses_rs1       = 1'b0;
        uses_rs2       = 1'b0;
        dec.funct3     = f3;
        dec.funct7     = f7;
        dec.write_addr = in_inst[11:7];
        dec.read_addr1 = in_inst[19:15];
        dec.read_addr2 = in_inst[24:20];

        case (opcode)
            OPC_OP_IMM: begin
                dec.write_en          = 1'b1;
                dec.immediate         = imm_i;
                dec.alu_src2_from_imm = 1'b1;
                dec.alu_opcode        = (f3 == 3'b101) ? {1'b0, in_inst[30], f3} : {2'b00, f3};
                uses_rd               = 1'b1;
                uses_rs1              = 1'b1;
                if (f3 == 3'b001 && f7 != F7_BASE)
                    bad = 1'b1;
                if (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT)
                    bad = 1'b1;
            end
            OPC_OP: begin
                dec.write_en = 1'b1;
                uses_rd      = 1'b1;
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
                if (f7 == F7_MUL) begin
                    if (ENABLE_M != 0)
                        dec.alu_opcode = {2'b10, f3};
                    else
                        bad = 1'b1;
                end else if (f7 == F7_BASE || f7 == F7_ALT) begin
                    dec.alu_opcode = {1'b0, in_inst[30], f3};
                end else begin
                    bad = 1'b1;
                end
            end
            OPC_LOAD: begin
                dec.mem_read_en       = 1'b1;
                dec.write_en          = 1'b1;
                dec.immediate         = imm_i;
                dec.alu_src2_from_imm = 1'b1;
                uses_rd               = 1'b1;
                uses_rs1              = 1'b1;
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)
                    bad = 1'b1;
            end
            OPC_STORE: begin
                dec.mem_write_en      = 1'b1;
                dec.immediate         = imm_s;
                dec.alu_src2_from_imm = 1'b1;
                uses_rs1              = 1'b1;
                uses_rs2              = 1'b1;
                if (f3[2] || f3 == 3'b011)
                    bad = 1'b1;
            end
            OPC_BRANCH: begin
                dec.branch_inst = 1'b1;
                dec.immediate   = imm_b;
                uses_rs1        = 1'b1;
                uses_rs2        = 1'b1;
                if (f3 == 3'b010 || f3 == 3'b011)
                    bad = 1'b1;
            end
            OPC_LUI: begin
                dec.write_en          = 1'b1;
                dec.immediate         = imm_u;
                dec.alu_src2_from_imm = 1'b1;
                dec.read_addr1        = 5'd0;
                uses_rd               = 1'b1;
            end
            OPC_AUIPC: begin
                dec.auipc_inst        = 1'b1;
                dec.write_en          = 1'b1;
                dec.immediate         = imm_u;
                dec.alu_src2_from_imm = 1'b1;
                uses_rd               = 1'b1;
            end
            OPC_JAL: begin
                dec.jal_inst  = 1'b1;
                dec.write_en  = 1'b1;
                dec.immediate = imm_j;
                uses_rd       = 1'b1;
            end
            OPC_JALR: begin
                dec.jalr_inst         = 1'b1;
                dec.write_en          = 1'b1;
                dec.immediate         = imm_i;
                dec.alu_src2_from_imm = 1'b1;
                uses_rd               = 1'b1;
                uses_rs1              = 1'b1;
                if (f3 != 3'b000)
                    bad = 1'b1;
            end
            OPC_FENCE: begin
                bad = 1'b0;
            end
            OPC_SYSTEM: begin
                // Only ECALL and EBREAK are supported; CSR ops are rejected.
                if (in_inst == 32'h0000_0073 || in_inst == 32'h0010_0073)
                    dec.sys_inst = 1'b1;
                else
                    bad = 1'b1;
            end
            default: begin
                bad = 1'b1;
            end
        endcase

        if (in_inst[1:0] != 2'b11)
            bad = 1'b1;

        if (RV32E != 0) begin
            if ((uses_rd && in_inst[11]) || (uses_rs1 && in_inst[19]) || (uses_rs2 && in_inst[24]))
                bad = 1'b1;
        end

        if (dec.write_addr == 5'd0)
            dec.write_en = 1'b0;

        if (bad) begin
            dec.write_en     = 1'b0;
            dec.mem_read_en  = 1'b0;
            dec.mem_write_en = 1'b0;
            dec.branch_inst  = 1'b0;
            dec.jal_inst     = 1'b0;
            dec.jalr_inst    = 1'b0;
            dec.auipc_inst   = 1'b0;
            dec.sys_inst     = 1'b0;
            dec.illegal_inst = 1'b1;
        end
    end

    // valid/ready: a beat moves when valid and ready are both high at a rising edge;
    // valid never waits on ready, and in_ready is a register equal to "skid empty".
    bundle_t               out_q;
    bundle_t               skid_q;
    logic [PC_WIDTH-1:0]   out_pc_q;
    logic [PC_WIDTH-1:0]   skid_pc_q;
    logic                  out_valid_q;
    logic                  skid_valid_q;
    logic                  in_ready_q;
    logic                  accept;

    assign accept = in_valid & in_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_pc_q     <= '0;
            skid_pc_q    <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                // in_ready was low, so nothing can be accepted alongside the skid refill.
                out_q        <= skid_q;
                out_pc_q     <= skid_pc_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
                in_ready_q   <= 1'b1;
            end else if (accept) begin
                out_q       <= dec;
                out_pc_q    <= in_pc;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_q       <= dec;
            skid_pc_q    <= in_pc;
            skid_valid_q <= 1'b1;
            in_ready_q   <= 1'b0;
        end
    end

    assign in_ready          = in_ready_q;
    assign out_valid         = out_valid_q;
    assign out_pc            = out_pc_q;
    assign write_en          = out_q.write_en;
    assign write_addr        = out_q.write_addr;
    assign read_addr1        = out_q.read_addr1;
    assign read_addr2        = out_q.read_addr2;
    assign immediate         = out_q.immediate;
    assign funct3            = out_q.funct3;
    assign funct7            = out_q.funct7;
    assign alu_opcode        = out_q.alu_opcode;
    assign alu_src2_from_imm = out_q.alu_src2_from_imm;
    assign mem_read_en       = out_q.mem_read_en;
    assign mem_write_en      = out_q.mem_write_en;
    assign branch_inst       = out_q.branch_inst;
    assign jal_inst          = out_q.jal_inst;
    assign jalr_inst         = out_q.jalr_inst;
    assign auipc_inst        = out_q.auipc_inst;
    assign sys_inst          = out_q.sys_inst;
    assign illegal_inst      = out_q.illegal_inst;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (base RV32I, and M+E) share one stimulus stream,
// checked every cycle against an ordered instruction queue and a rule-level decode model.
module tb_decode_stage;

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  alu;
    logic        src2;
    logic        mrd;
    logic        mwr;
    logic        br;
    logic        jal;
    logic        jalr;
    logic        auipc;
    logic        sys;
    logic        ill;
  } bund_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = 32'h0;
  logic [31:0] in_pc = 32'h0;
  logic        out_ready = 1'b0;

  logic        in_ready [2];
  logic        out_valid [2];
  logic [31:0] out_pc [2];
  bund_t       got [2];

  int checks = 0;
  int errors = 0;
  bit rand_bp = 0;
  logic [31:0] pc_ctr = 32'h1000;
  txn_t exp_q[$];

  always #5 clk = ~clk;

  decode_stage #(.ENABLE_M(0), .RV32E(0), .PC_WIDTH(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready[0]), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_pc(out_pc[0]),
    .write_en(got[0].we), .write_addr(got[0].wa), .read_addr1(got[0].ra1), .read_addr2(got[0].ra2),
    .immediate(got[0].imm), .funct3(got[0].f3), .funct7(got[0].f7), .alu_opcode(got[0].alu),
    .alu_src2_from_imm(got[0].src2), .mem_read_en(got[0].mrd), .mem_write_en(got[0].mwr),
    .branch_inst(got[0].br), .jal_inst(got[0].jal), .jalr_inst(got[0].jalr),
    .auipc_inst(got[0].auipc), .sys_inst(got[0].sys), .illegal_inst(got[0].ill)
  );

  decode_stage #(.ENABLE_M(1), .RV32E(1), .PC_WIDTH(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready[1]), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_pc(out_pc[1]),
    .write_en(got[1].we), .write_addr(got[1].wa), .read_addr1(got[1].ra1), .read_addr2(got[1].ra2),
    .immediate(got[1].imm), .funct3(got[1].f3), .funct7(got[1].f7), .alu_opcode(got[1].alu),
    .alu_src2_from_imm(got[1].src2), .mem_read_en(got[1].mrd), .mem_write_en(got[1].mwr),
    .branch_inst(got[1].br), .jal_inst(got[1].jal), .jalr_inst(got[1].jalr),
    .auipc_inst(got[1].auipc), .sys_inst(got[1].sys), .illegal_inst(got[1].ill)
  );

  // Decode rules written per instruction class.
  function automatic bund_t model(input logic [31:0] i, input bit em, input bit e32);
    bund_t b;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit bad, urd, urs1, urs2;
    b = '0;
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    b.f3 = f3;
    b.f7 = f7;
    b.wa = i[11:7];
    b.ra1 = i[19:15];
    b.ra2 = i[24:20];
    bad = 0; urd = 0; urs1 = 0; urs2 = 0;
    if (op == 7'h13) begin
      b.we = 1; urd = 1; urs1 = 1; b.src2 = 1;
      b.imm = 32'($signed(i[31:20]));
      b.alu = (f3 == 3'd5) ? {1'b0, i[30], f3} : {2'b0, f3};
      if (f3 == 3'd1) bad = (f7 != 7'h00);
      if (f3 == 3'd5) bad = !(f7 inside {7'h00, 7'h20});
    end else if (op == 7'h33) begin
      b.we = 1; urd = 1; urs1 = 1; urs2 = 1;
      if (f7 == 7'h01) begin
        bad = !em;
        b.alu = {2'b10, f3};
      end else begin
        bad = !(f7 inside {7'h00, 7'h20});
        b.alu = {1'b0, f7[5], f3};
      end
    end else if (op == 7'h03) begin
      b.mrd = 1; b.we = 1; urd = 1; urs1 = 1; b.src2 = 1;
      b.imm = 32'($signed(i[31:20]));
      bad = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    end else if (op == 7'h23) begin
      b.mwr = 1; urs1 = 1; urs2 = 1; b.src2 = 1;
      b.imm = 32'($signed({i[31:25], i[11:7]}));
      bad = (f3 > 3'd2);
    end else if (op == 7'h63) begin
      b.br = 1; urs1 = 1; urs2 = 1;
      b.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      bad = (f3 == 3'd2 || f3 == 3'd3);
    end else if (op == 7'h37) begin
      b.we = 1; urd = 1; b.src2 = 1; b.ra1 = 0;
      b.imm = i & 32'hFFFF_F000;
    end else if (op == 7'h17) begin
      b.auipc = 1; b.we = 1; urd = 1; b.src2 = 1;
      b.imm = i & 32'hFFFF_F000;
    end else if (op == 7'h6F) begin
      b.jal = 1; b.we = 1; urd = 1;
      b.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
    end else if (op == 7'h67) begin
      b.jalr = 1; b.we = 1; urd = 1; urs1 = 1; b.src2 = 1;
      b.imm = 32'($signed(i[31:20]));
      bad = (f3 != 3'd0);
    end else if (op == 7'h0F) begin
      bad = 0;
    end else if (op == 7'h73) begin
      b.sys = 1;
      bad = !(i == 32'h73 || i == 32'h0010_0073);
    end else begin
      bad = 1;
    end
    if (e32 && ((urd && b.wa >= 16) || (urs1 && b.ra1 >= 16) || (urs2 && b.ra2 >= 16))) bad = 1;
    if (b.wa == 0) b.we = 0;
    if (bad) begin
      b.we = 0; b.mrd = 0; b.mwr = 0; b.br = 0; b.jal = 0; b.jalr = 0; b.auipc = 0; b.sys = 0;
      b.ill = 1;
    end
    return b;
  endfunction

  // Operand fields of an illegal bundle carry no meaning, so they are not compared.
  function automatic bund_t view(input bund_t b);
    bund_t v;
    v = b;
    if (v.ill) begin
      v.imm = 0; v.alu = 0; v.src2 = 0; v.wa = 0; v.ra1 = 0; v.ra2 = 0;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Scoreboard: each negedge checks both DUTs against the queue, then applies the upcoming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("out_valid[%0d]", d), {31'b0, out_valid[d]}, {31'b0, exp_q.size() > 0});
        chk($sformatf("in_ready[%0d]", d), {31'b0, in_ready[d]}, {31'b0, exp_q.size() < 2});
        if (out_valid[d] && exp_q.size() > 0) begin
          bund_t e;
          e = model(exp_q[0].inst, d == 1, d == 1);
          chk($sformatf("out_pc[%0d]", d), out_pc[d], exp_q[0].pc);
          checks++;
          if (view(got[d]) !== view(e)) begin
            errors++;
            $display("FAIL bundle[%0d] inst %08h: got %018h expected %018h", d, exp_q[0].inst,
                     view(got[d]), view(e));
          end
        end
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid[0] && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (in_valid && in_ready[0]) exp_q.push_back('{inst: in_inst, pc: in_pc});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction and returns #1 after the edge that accepted it.
  task automatic send(input logic [31:0] inst);
    bit done;
    done = 0;
    in_valid = 1;
    in_inst = inst;
    in_pc = pc_ctr;
    for (int n = 0; n < 50 && !done; n++) begin
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      done = in_ready[0];
      step();
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 0;
    pc_ctr += 4;
  endtask

  logic [31:0] prog [16] = '{
    32'h40115093, 32'h02011093, 32'h123450B7, 32'h00001197, 32'h0020A223, 32'h00208463,
    32'h0020A463, 32'h000080E7, 32'h000090E7, 32'h0040A183, 32'h00003003, 32'h00000073,
    32'h00100073, 32'h00200073, 32'h0000000F, 32'h00000000
  };

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc_a, pc_b, pc_c;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    #1;
    chk("reset_out_valid", {31'b0, out_valid[0]}, 32'd0);
    chk("reset_in_ready", {31'b0, in_ready[0]}, 32'd1);
    chk("reset_immediate", got[0].imm, 32'd0);
    chk("reset_write_en", {31'b0, got[0].we}, 32'd0);

    out_ready = 1;
    send(32'hFFF10093);
    chk("addi_valid", {31'b0, out_valid[0]}, 32'd1);
    chk("addi_wa", {27'b0, got[0].wa}, 32'd1);
    chk("addi_ra1", {27'b0, got[0].ra1}, 32'd2);
    chk("addi_imm", got[0].imm, 32'hFFFFFFFF);
    chk("addi_alu", {27'b0, got[0].alu}, 32'd0);
    chk("addi_src2", {31'b0, got[0].src2}, 32'd1);
    chk("addi_we", {31'b0, got[0].we}, 32'd1);

    send(32'h022081B3);
    chk("mul_m0_ill", {31'b0, got[0].ill}, 32'd1);
    chk("mul_m0_we", {31'b0, got[0].we}, 32'd0);
    chk("mul_m1_alu", {27'b0, got[1].alu}, 32'h10);
    chk("mul_m1_we", {31'b0, got[1].we}, 32'd1);
    chk("mul_m1_ill", {31'b0, got[1].ill}, 32'd0);

    send(32'h000008B3);
    chk("add17_e0_ill", {31'b0, got[0].ill}, 32'd0);
    chk("add17_e0_wa", {27'b0, got[0].wa}, 32'd17);
    chk("add17_e1_ill", {31'b0, got[1].ill}, 32'd1);

    send(32'h008000EF);
    chk("jal_flag", {31'b0, got[0].jal}, 32'd1);
    chk("jal_imm", got[0].imm, 32'd8);
    chk("jal_we", {31'b0, got[0].we}, 32'd1);
    send(32'h00000013);
    chk("nop_we", {31'b0, got[0].we}, 32'd0);
    step();

    // Backpressure: A in output, B in skid, C refused until space frees.
    out_ready = 0;
    pc_a = pc_ctr; send(32'h00100093);
    pc_b = pc_ctr; send(32'h00200113);
    chk("bp_in_ready", {31'b0, in_ready[0]}, 32'd0);
    pc_c = pc_ctr;
    in_valid = 1; in_inst = 32'h00300193; in_pc = pc_c;
    step();
    chk("bp_hold_a", out_pc[0], pc_a);
    chk("bp_c_refused", {31'b0, in_ready[0]}, 32'd0);
    out_ready = 1;
    step();
    chk("bp_emit_b", out_pc[0], pc_b);
    step();
    in_valid = 0;
    pc_ctr += 4;
    chk("bp_emit_c", out_pc[0], pc_c);
    step();
    chk("bp_drained", {31'b0, out_valid[0]}, 32'd0);

    // Flush with the skid full and a new instruction offered in the same cycle.
    out_ready = 0;
    send(32'h00400213);
    send(32'h00500293);
    in_valid = 1; in_inst = 32'h00600313; in_pc = pc_ctr; flush = 1;
    step();
    flush = 0; in_valid = 0; pc_ctr += 4;
    chk("flush_out_valid", {31'b0, out_valid[0]}, 32'd0);
    chk("flush_in_ready", {31'b0, in_ready[0]}, 32'd1);
    out_ready = 1;
    repeat (3) step();
    chk("flush_no_emit", {31'b0, out_valid[0]}, 32'd0);

    // Mixed stream with random backpressure.
    rand_bp = 1;
    for (int k = 0; k < 60; k++) send(prog[$urandom_range(0, 15)]);
    rand_bp = 0;
    out_ready = 1;
    repeat (4) step();

    // Asynchronous reset in the middle of a held stream.
    out_ready = 0;
    send(32'hFFF10093);
    send(32'h008000EF);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid[0]}, 32'd0);
    chk("arst_in_ready", {31'b0, in_ready[0]}, 32'd1);
    chk("arst_immediate", got[0].imm, 32'd0);
    chk("arst_write_en", {31'b0, got[0].we}, 32'd0);
    chk("arst_out_pc", out_pc[0], 32'd0);
    @(posedge clk);
    #2 rst_n = 1;
    out_ready = 1;
    send(32'h00000073);
    chk("post_reset_sys", {31'b0, got[0].sys}, 32'd1);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
